// File: rtl/simulator_pkg.sv
// Shared definitions for the simulator block.
//   sim_state_e : 2-bit phase encoding presented on the state output.
package simulator_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10,
    ST_DONE  = 2'b11
  } sim_state_e;

endpackage

// File: rtl/simulator_cycle_counter.sv
// Saturating up-counter used as the simulated-cycle index.
//   clk, rst_n : clock, async active-low reset (clears count)
//   en         : advance by one unless already at all-ones
//   clr        : synchronous clear to zero (wins over en)
//   count      : current value
//   at_max     : count is all-ones
module cycle_counter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             at_max
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  assign at_max = &count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            count <= '0;
    else if (clr)          count <= '0;
    else if (en && !at_max) count <= count + ONE;  // saturate, never wrap
  end

endmodule

// File: rtl/simulator.sv
// Cycle-based simulation sequencer: INIT -> RUN (2^MAX_CYCLE_WIDTH cycles)
// -> DRAIN (one cycle) -> DONE (terminal until reset).
//   clk           : single clock, rising edge
//   reset_n       : async active-low reset, forces INIT / cycle 0
//   state         : current phase (INIT/RUN/DRAIN/DONE), registered
//   current_cycle : current simulated cycle index, registered
module simulator
  import simulator_pkg::*;
#(
  parameter int MAX_CYCLE_WIDTH = 5
) (
  input  logic                       clk,
  input  logic                       reset_n,
  output logic [1:0]                 state,
  output logic [MAX_CYCLE_WIDTH-1:0] current_cycle
);

  sim_state_e state_q, state_d;
  logic       cnt_en, cnt_clr, cnt_max;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_INIT;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_en  = 1'b0;
    cnt_clr = 1'b0;
    case (state_q)
      ST_INIT: begin
        // Counter is held at 0 across the INIT->RUN edge so RUN opens at cycle 0.
        cnt_clr = 1'b1;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (cnt_max) state_d = ST_DRAIN;
        else         cnt_en  = 1'b1;
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_DONE;
      default: begin
        cnt_clr = 1'b1;
        state_d = ST_INIT;
      end
    endcase
  end

  cycle_counter #(.WIDTH(MAX_CYCLE_WIDTH)) u_cnt (
    .clk    (clk),
    .rst_n  (reset_n),
    .en     (cnt_en),
    .clr    (cnt_clr),
    .count  (current_cycle),
    .at_max (cnt_max)
  );

  assign state = state_q;

endmodule

// File: tb/tb_simulator.sv
`timescale 1ps/1ps
module tb_simulator;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] st5, st3;
  logic [4:0] cc5;
  logic [2:0] cc3;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [1:0] s5;
    logic [4:0] c5;
    logic [1:0] s3;
    logic [2:0] c3;
  } exp_t;

  exp_t sb[$];

  always #10 clk = ~clk;  // 20 ps period

  simulator dut (
    .clk(clk), .reset_n(reset_n), .state(st5), .current_cycle(cc5)
  );

  simulator #(.MAX_CYCLE_WIDTH(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .state(st3), .current_cycle(cc3)
  );

  // Expected outputs after the k-th rising edge following reset release.
  function automatic exp_t exp_at(int k);
    exp_t e;
    if (k <= 32)      begin e.s5 = 2'b01; e.c5 = 5'(k - 1); end
    else if (k == 33) begin e.s5 = 2'b10; e.c5 = 5'd31; end
    else              begin e.s5 = 2'b11; e.c5 = 5'd31; end
    if (k <= 8)       begin e.s3 = 2'b01; e.c3 = 3'(k - 1); end
    else if (k == 9)  begin e.s3 = 2'b10; e.c3 = 3'd7; end
    else              begin e.s3 = 2'b11; e.c3 = 3'd7; end
    return e;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({st5, cc5} !== 7'b0) begin
        n_bad++;
        $display("FAIL reset_w5 got %b/%0d want 00/0", st5, cc5);
      end
      n_cmp++;
      if ({st3, cc3} !== 5'b0) begin
        n_bad++;
        $display("FAIL reset_w3 got %b/%0d want 00/0", st3, cc3);
      end
    end
  endtask

  // Release at a falling edge, then check every edge up to nedges.
  task automatic run_from_release(string tag, int nedges);
    exp_t e;
    reset_n = 1'b1;
    for (int k = 1; k <= nedges; k++) begin
      sb.push_back(exp_at(k));
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if ({st5, cc5} !== {e.s5, e.c5}) begin
        n_bad++;
        $display("FAIL %s_w5 edge %0d got %b/%0d want %b/%0d", tag, k, st5, cc5, e.s5, e.c5);
      end
      n_cmp++;
      if ({st3, cc3} !== {e.s3, e.c3}) begin
        n_bad++;
        $display("FAIL %s_w3 edge %0d got %b/%0d want %b/%0d", tag, k, st3, cc3, e.s3, e.c3);
      end
    end
  endtask

  task automatic test_run_drain_done();
    run_from_release("run", 34);
  endtask

  task automatic test_done_hold();
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({st5, cc5} !== {2'b11, 5'd31} || {st3, cc3} !== {2'b11, 3'd7}) begin
        n_bad++;
        $display("FAIL done_hold cyc %0d got %b/%0d %b/%0d want 11/31 11/7", i, st5, cc5, st3, cc3);
      end
    end
  endtask

  task automatic async_reset_check(string tag);
    reset_n = 1'b0;
    #1;  // well before the next rising edge
    n_cmp++;
    if ({st5, cc5, st3, cc3} !== 12'b0) begin
      n_bad++;
      $display("FAIL %s got %b/%0d %b/%0d want 00/0 00/0", tag, st5, cc5, st3, cc3);
    end
  endtask

  task automatic test_reset_in_done();
    async_reset_check("async_rst_done");
    @(negedge clk);  // rising edge in between must not move anything
    n_cmp++;
    if ({st5, cc5, st3, cc3} !== 12'b0) begin
      n_bad++;
      $display("FAIL rst_priority got %b/%0d %b/%0d want 00/0 00/0", st5, cc5, st3, cc3);
    end
  endtask

  task automatic test_mid_run_reset();
    run_from_release("pre", 13);  // w5 now at cycle 12, still RUN
    n_cmp++;
    if ({st5, cc5} !== {2'b01, 5'd12}) begin
      n_bad++;
      $display("FAIL mid_run_pos got %b/%0d want 01/12", st5, cc5);
    end
    async_reset_check("async_rst_run");
    @(negedge clk);
    run_from_release("restart", 34);
  endtask

  initial begin
    test_reset();
    test_run_drain_done();
    test_done_hold();
    test_reset_in_done();
    test_mid_run_reset();
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_left got %0d want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
